// File: rtl/dsp_simd_mul2x_comp.sv
// SIMD 2x multiplier: two unsigned pixels packed 18 bits apart share one signed
// coefficient multiply; emits raw high segment, low segment and compensate bit.
module dsp_simd_mul2x_comp #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 10
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              clken,
  input  logic              dsp_reset,
  input  logic [PIX_W-1:0]  pix_h,
  input  logic [PIX_W-1:0]  pix_l,
  input  logic [COEF_W-1:0] coef,
  input  logic              first_in,
  input  logic              valid_in,
  output logic [17:0]       outh,
  output logic [17:0]       outl,
  output logic              cin,
  output logic              mode_out,
  output logic              valid_out
);

  localparam int PROD_W = 48;

  generate
    if (PIX_W + COEF_W > 18) begin : g_width_check
      $error("dsp_simd_mul2x_comp: PIX_W + COEF_W must not exceed 18");
    end
  endgenerate

  logic [1:0]               rst_sync_r;
  logic                     rst_n_s;

  logic [PIX_W-1:0]         pix_h_r;
  logic [PIX_W-1:0]         pix_l_r;
  logic signed [COEF_W-1:0] coef_r;
  logic                     first1_r;
  logic                     valid1_r;

  logic [35:0]              m_r;
  logic                     first2_r;
  logic                     valid2_r;

  logic [17:0]              outh_r;
  logic [17:0]              outl_r;
  logic                     cin_r;
  logic                     mode_r;
  logic                     valid_r;

  logic signed [PROD_W-1:0] a_s;
  logic signed [PROD_W-1:0] b_s;
  logic signed [PROD_W-1:0] prod_s;
  logic                     prod_unused_s;

  // Reset synchronizer: asserts immediately, releases on the clock.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Packed multiply: pixel low segment sits at bit 0, high segment at bit 18.
  always_comb begin
    a_s                = {PROD_W{1'b0}};
    a_s[18 +: PIX_W]   = pix_h_r;
    a_s[0 +: PIX_W]    = pix_l_r;
    b_s                = {{(PROD_W-COEF_W){coef_r[COEF_W-1]}}, coef_r};
    prod_s             = a_s * b_s;
  end

  // Bits above 36 carry only sign extension of the packed product.
  assign prod_unused_s = ^prod_s[PROD_W-1:36];

  // Three-stage pipeline with sideband; dsp_reset beats clken.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pix_h_r  <= {PIX_W{1'b0}};
      pix_l_r  <= {PIX_W{1'b0}};
      coef_r   <= {COEF_W{1'b0}};
      first1_r <= 1'b0;
      valid1_r <= 1'b0;
      m_r      <= 36'd0;
      first2_r <= 1'b0;
      valid2_r <= 1'b0;
      outh_r   <= 18'd0;
      outl_r   <= 18'd0;
      cin_r    <= 1'b0;
      mode_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else if (!rst_n_s || dsp_reset) begin
      pix_h_r  <= {PIX_W{1'b0}};
      pix_l_r  <= {PIX_W{1'b0}};
      coef_r   <= {COEF_W{1'b0}};
      first1_r <= 1'b0;
      valid1_r <= 1'b0;
      m_r      <= 36'd0;
      first2_r <= 1'b0;
      valid2_r <= 1'b0;
      outh_r   <= 18'd0;
      outl_r   <= 18'd0;
      cin_r    <= 1'b0;
      mode_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else if (clken) begin
      pix_h_r  <= pix_h;
      pix_l_r  <= pix_l;
      coef_r   <= coef;
      first1_r <= first_in;
      valid1_r <= valid_in;
      m_r      <= prod_s[35:0];
      first2_r <= first1_r;
      valid2_r <= valid1_r;
      outh_r   <= m_r[35:18];
      outl_r   <= m_r[17:0];
      cin_r    <= m_r[17];
      mode_r   <= valid2_r & ~first2_r;
      valid_r  <= valid2_r;
    end else begin
      pix_h_r  <= pix_h_r;
      pix_l_r  <= pix_l_r;
      coef_r   <= coef_r;
      first1_r <= first1_r;
      valid1_r <= valid1_r;
      m_r      <= m_r;
      first2_r <= first2_r;
      valid2_r <= valid2_r;
      outh_r   <= outh_r;
      outl_r   <= outl_r;
      cin_r    <= cin_r;
      mode_r   <= mode_r;
      valid_r  <= valid_r;
    end
  end

  assign outh      = outh_r;
  assign outl      = outl_r;
  assign cin       = cin_r;
  assign mode_out  = mode_r;
  assign valid_out = valid_r;

endmodule

// File: tb/tb_dsp_simd_mul2x_comp.sv
// Directed and randomized self-checking bench for dsp_simd_mul2x_comp.
module tb_dsp_simd_mul2x_comp;

  logic              clk;
  logic              aresetn;
  logic              clken;
  logic              dsp_reset;
  logic [7:0]        pix_h;
  logic [7:0]        pix_l;
  logic signed [9:0] coef;
  logic              first_in;
  logic              valid_in;
  logic [17:0]       outh;
  logic [17:0]       outl;
  logic              cin;
  logic              mode_out;
  logic              valid_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        v;
    logic        m;
    logic [17:0] h;
    logic [17:0] l;
    logic [17:0] full_h;
  } slot_t;

  slot_t mdl [3];

  dsp_simd_mul2x_comp #(.PIX_W(8), .COEF_W(10)) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .clken     (clken),
    .dsp_reset (dsp_reset),
    .pix_h     (pix_h),
    .pix_l     (pix_l),
    .coef      (coef),
    .first_in  (first_in),
    .valid_in  (valid_in),
    .outh      (outh),
    .outl      (outl),
    .cin       (cin),
    .mode_out  (mode_out),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%05h expected=0x%05h", tag, obs, exp);
    end
  endtask

  function automatic slot_t expect_of(input logic [7:0] ph, input logic [7:0] pl,
                                      input logic signed [9:0] c, input logic f, input logic v);
    slot_t s;
    int hi;
    int lo;
    int r;
    hi       = int'(ph) * int'(c);
    lo       = int'(pl) * int'(c);
    r        = hi - ((lo < 0) ? 1 : 0);
    s.v      = v;
    s.m      = v & ~f;
    s.h      = r[17:0];
    s.l      = lo[17:0];
    s.full_h = hi[17:0];
    return s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      mdl[i] = '{1'b0, 1'b0, 18'd0, 18'd0, 18'd0};
    end
  endtask

  task automatic check_out(input string tag);
    cmp({tag, ".valid"}, {17'd0, valid_out}, {17'd0, mdl[2].v});
    cmp({tag, ".mode"},  {17'd0, mode_out},  {17'd0, mdl[2].m});
    cmp({tag, ".cin_eq_outl17"}, {17'd0, cin}, {17'd0, outl[17]});
    if (mdl[2].v) begin
      cmp({tag, ".outh"}, outh, mdl[2].h);
      cmp({tag, ".outl"}, outl, mdl[2].l);
      cmp({tag, ".recover"}, outh + {17'd0, cin}, mdl[2].full_h);
    end
  endtask

  // One clock edge: advance the reference pipeline, then check outputs after it.
  task automatic clock(input string tag);
    @(posedge clk);
    if (!aresetn || dsp_reset) begin
      model_clear();
    end else if (clken) begin
      mdl[2] = mdl[1];
      mdl[1] = mdl[0];
      mdl[0] = expect_of(pix_h, pix_l, coef, first_in, valid_in);
    end
    #1;
    check_out(tag);
  endtask

  task automatic drive(input logic [7:0] ph, input logic [7:0] pl,
                       input logic signed [9:0] c, input logic f, input logic v);
    pix_h    = ph;
    pix_l    = pl;
    coef     = c;
    first_in = f;
    valid_in = v;
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, ".outh"},  outh, 18'd0);
    cmp({tag, ".outl"},  outl, 18'd0);
    cmp({tag, ".cin"},   {17'd0, cin}, 18'd0);
    cmp({tag, ".mode"},  {17'd0, mode_out}, 18'd0);
    cmp({tag, ".valid"}, {17'd0, valid_out}, 18'd0);
  endtask

  task automatic stream4(input string tag, input logic stall);
    logic [7:0]        ph [4];
    logic [7:0]        pl [4];
    logic signed [9:0] cf [4];
    ph = '{8'd12, 8'd200, 8'd0, 8'd77};
    pl = '{8'd34, 8'd1, 8'd255, 8'd128};
    cf = '{10'sd5, -10'sd7, 10'sd100, -10'sd300};
    for (int i = 0; i < 4; i++) begin
      drive(ph[i], pl[i], cf[i], (i == 0) ? 1'b1 : 1'b0, 1'b1);
      clock(tag);
      if (stall && i == 1) begin
        clken = 1'b0;
        drive(8'd9, 8'd9, 10'sd9, 1'b1, 1'b1);
        clock(tag);
        clock(tag);
        clken = 1'b1;
      end
    end
    drive(8'd0, 8'd0, 10'sd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      clock(tag);
    end
  endtask

  initial begin
    aresetn   = 1'b0;
    clken     = 1'b1;
    dsp_reset = 1'b0;
    drive(8'd0, 8'd0, 10'sd0, 1'b0, 1'b0);
    model_clear();
    clock("reset");
    check_zero("reset");
    #2 aresetn = 1'b1;
    for (int i = 0; i < 3; i++) clock("sync_release");

    // Three back-to-back directed samples with hand-computed results.
    drive(8'd10, 8'd20, -10'sd3, 1'b1, 1'b1);
    clock("dir");
    drive(8'd255, 8'd255, 10'sd511, 1'b1, 1'b1);
    clock("dir");
    drive(8'd255, 8'd255, -10'sd512, 1'b0, 1'b1);
    clock("dir");
    cmp("neg3.outl", outl, 18'h3FFC4);
    cmp("neg3.cin", {17'd0, cin}, 18'd1);
    cmp("neg3.outh", outh, 18'h3FFE1);
    cmp("neg3.mode", {17'd0, mode_out}, 18'd0);
    cmp("neg3.valid", {17'd0, valid_out}, 18'd1);
    drive(8'd200, 8'd100, 10'sd0, 1'b1, 1'b1);
    clock("dir");
    cmp("maxpos.outl", outl, 18'h1FD01);
    cmp("maxpos.cin", {17'd0, cin}, 18'd0);
    cmp("maxpos.outh", outh, 18'h1FD01);
    drive(8'd0, 8'd0, 10'sd0, 1'b0, 1'b0);
    clock("dir");
    cmp("maxneg.outl", outl, 18'h20200);
    cmp("maxneg.cin", {17'd0, cin}, 18'd1);
    cmp("maxneg.outh", outh, 18'h201FF);
    cmp("maxneg.mode", {17'd0, mode_out}, 18'd1);
    clock("dir");
    cmp("zero.outh", outh, 18'd0);
    cmp("zero.outl", outl, 18'd0);
    cmp("zero.valid", {17'd0, valid_out}, 18'd1);
    clock("dir");
    cmp("idle.valid", {17'd0, valid_out}, 18'd0);

    stream4("stream", 1'b0);
    stream4("stall", 1'b1);

    // Two samples in flight, then dsp_reset with clken low: must still clear.
    drive(8'd50, 8'd60, 10'sd70, 1'b1, 1'b1);
    clock("dsprst");
    drive(8'd51, 8'd61, 10'sd71, 1'b0, 1'b1);
    clock("dsprst");
    drive(8'd0, 8'd0, 10'sd0, 1'b0, 1'b0);
    dsp_reset = 1'b1;
    clken     = 1'b0;
    clock("dsprst");
    check_zero("dsprst");
    dsp_reset = 1'b0;
    clken     = 1'b1;
    drive(8'd3, 8'd4, -10'sd5, 1'b1, 1'b1);
    clock("dsprst");
    drive(8'd0, 8'd0, 10'sd0, 1'b0, 1'b0);
    clock("dsprst");
    cmp("dsprst.gap_valid", {17'd0, valid_out}, 18'd0);
    clock("dsprst");
    cmp("dsprst.new_valid", {17'd0, valid_out}, 18'd1);
    cmp("dsprst.new_outl", outl, 18'h3FFEC);
    cmp("dsprst.new_outh", outh, 18'h3FFF0);

    // Asynchronous reset between edges mid-stream.
    drive(8'd90, 8'd91, 10'sd92, 1'b1, 1'b1);
    clock("areset");
    clock("areset");
    clock("areset");
    #3 aresetn = 1'b0;
    #1;
    check_zero("areset");
    model_clear();
    clock("areset_hold");
    #2 aresetn = 1'b1;
    drive(8'd0, 8'd0, 10'sd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) clock("areset_release");

    // Randomized stream against the reference model.
    for (int i = 0; i < 10000; i++) begin
      drive(8'($urandom_range(255)), 8'($urandom_range(255)),
            10'($urandom_range(1023)), 1'($urandom_range(1)),
            ($urandom_range(7) != 0) ? 1'b1 : 1'b0);
      clken     = ($urandom_range(7) != 0) ? 1'b1 : 1'b0;
      dsp_reset = ($urandom_range(255) == 0) ? 1'b1 : 1'b0;
      clock("rand");
    end
    clken     = 1'b1;
    dsp_reset = 1'b0;
    drive(8'd0, 8'd0, 10'sd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) clock("drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dsp_simd_mul2x_comp.md
Name: dsp_simd_mul2x_comp

Overview:
- Producer side of the compensate-carry accumulation interface: a SIMD 2x multiplier that packs two unsigned pixels into one DSP multiply against a shared signed coefficient.
- Emits the raw high segment OUTH, the low segment OUTL, and the compensate bit CIN = OUTL[17].
- Also emits a MODE flag (preload vs accumulate) and a valid flag, so downstream cascade accumulators consume it directly.
- Sits in the bicubic tap datapath between pixel fetch and the cascade adder/accumulator chain.

Parameters:
- PIX_W, 8, unsigned pixel width for each packed operand.
- COEF_W, 10, signed coefficient width. Elaboration error unless PIX_W+COEF_W <= 18.

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset; clears all registers
- clken  in  1  global clock enable; 0 freezes every pipeline register, outputs hold
- dsp_reset  in  1  synchronous reset of all pipeline registers, effective regardless of clken
- pix_h  in  PIX_W  unsigned pixel for the high segment
- pix_l  in  PIX_W  unsigned pixel for the low segment
- coef  in  COEF_W  signed shared coefficient
- first_in  in  1  marks the first tap of an accumulation group
- valid_in  in  1  input sample valid
- outh  out  18  high segment, uncompensated
- outl  out  18  low segment (signed)
- cin  out  1  compensate bit, always equal to outl[17]
- mode_out  out  1  0 = preload (first tap), 1 = accumulate
- valid_out  out  1  output valid

Behaviour:
- Packed product: P = (pix_h*2^18 + pix_l) * coef, computed at full width of at least 45 bits, signed.
- outl = P[17:0], which equals pix_l*coef as an 18-bit two's-complement value. It is exact because |pix_l*coef| < 2^17.
- outh = P[35:18], which equals pix_h*coef - (pix_l*coef < 0 ? 1 : 0), mod 2^18.
- Downstream outh + cin recovers pix_h*coef exactly.
- Pipeline has 3 enabled stages:
  - S1: input registers for pix_h, pix_l, coef, first_in, valid_in.
  - S2: product register (M).
  - S3: output register (P), split into outh/outl/cin.
- Latency is exactly 3 clken-high cycles from input to output, throughput 1 sample per enabled cycle.
- Control sideband (valid, first) is delayed in a shift register of identical depth and identical enables, so data and flags stay aligned.
- mode_out = ~first at S3. When valid_out = 0, mode_out is 0.
- When valid_in = 0, data registers still load (don't-care contents). valid_out = 0 for that slot and outh/outl/cin are not meaningful.
- clken low: no register changes, including the sideband. Resuming continues exactly where it stopped; no sample is dropped or duplicated.
- dsp_reset high at a clock edge: all stages are cleared to 0 on that edge, with priority over clken. Samples in flight are discarded; the first valid output appears 3 enabled cycles after the first post-reset valid input.
- aresetn low: immediate clear independent of clk. Release is synchronous to the design's reset synchronizer.
- Reset values: outh = 0, outl = 0, cin = 0, mode_out = 0, valid_out = 0.
- Extremes must be exact without overflow:
  - pix = 2^PIX_W-1 with coef = -2^(COEF_W-1).
  - pix = 2^PIX_W-1 with coef = 2^(COEF_W-1)-1.
  - coef = 0 gives outh = outl = 0, cin = 0.
- Implementation: infer the DSP, or instantiate DSP48E2 under USE_DSP48E2_PRIMITIVE. Both variants must be cycle-identical.

Test Plan:
- pix_h=10, pix_l=20, coef=-3, first_in=1 -> after 3 cycles: outl=0x3FFC4, cin=1, outh=0x3FFE1 (-31), mode_out=0, valid_out=1.
- pix_h=255, pix_l=255, coef=511 -> outl=0x1FD01, cin=0, outh=0x1FD01. Then coef=-512 -> outl=0x20200, cin=1, outh=0x201FF.
- Back-to-back stream of 4 taps with first_in=1,0,0,0 -> valid_out high for 4 consecutive cycles, mode_out=0,1,1,1. A reference model checks outh+cin == pix_h*coef every cycle.
- Same stream with clken toggled 0 for 2 cycles mid-stream -> outputs hold during the stall, sequence and values identical to the unstalled run.
- dsp_reset pulsed with 2 samples in flight -> those samples never appear, outputs become 0 the next cycle, and a new sample emerges exactly 3 cycles after it is applied.
- aresetn asserted asynchronously between edges mid-stream -> all outputs 0 immediately. Randomized 10k-sample run after release -> zero mismatches against the golden model.
